shared_data_tx: RTL and testbench

Transmit-side framer for the SFP event/shared-data link. Each cycle it builds one 16-bit word for the GTP transmitter: the low byte carries event codes and K28.5 commas, and the high byte alternates between the distributed bus and the segmented data channel. Segment contents are held in an internal buffer, and whole 16-byte segments are sent as framed packets (start, address, data, stop, checksum). It is the transmit counterpart of `shared_data_rx_wrapper` and replaces the simulation-only frame generator in the TX path.

---
 rtl/shared_data_pkg.sv | 20 ++
 rtl/shared_data_seg_ram.sv | 25 ++
 rtl/shared_data_tx.sv | 158 +++++++++++++++
 tb/tb_shared_data_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_data_pkg.sv
// Shared constants and types for the SFP shared-data transmit framer.
package shared_data_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K28_2     = 8'h5C;
  localparam logic [7:0] K28_1     = 8'h3C;
  localparam int         SEG_BYTES = 16;
  localparam int         CKS_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_DATA,
    ST_STOP,
    ST_CKS_HI,
    ST_CKS_LO
  } seg_state_t;

endpackage

// File: rtl/shared_data_seg_ram.sv
// Segment buffer: SEG_COUNT x 16 bytes, synchronous write, asynchronous read.
// The asynchronous read gives read-first behaviour on a same-edge collision.
module shared_data_seg_ram
  import shared_data_pkg::*;
#(
  parameter int SEG_COUNT = 32
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(SEG_COUNT)+3:0]  wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic [$clog2(SEG_COUNT)+3:0]  rd_addr,
  output logic [7:0]                    rd_data
);

  logic [7:0] mem [SEG_COUNT*SEG_BYTES];

  // Write port, independent of any framing activity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/shared_data_tx.sv
// Transmit-side framer for the SFP event/shared-data link.
// Low byte: event codes and periodic K28.5 commas.
// High byte: dbus on even phase, segment packet channel on odd phase.
// Optional macro SHARED_DATA_TX_CHECKSUM_EN appends CKS_HI/CKS_LO to each frame.
//
// state     | meaning
// ST_IDLE   | no frame, channel byte 0x00
// ST_START  | next odd slot emits K28.2
// ST_ADDR   | next odd slot emits the segment number
// ST_DATA   | next odd slot emits segment byte byte_idx
// ST_STOP   | next odd slot emits K28.1
// ST_CKS_HI | next odd slot emits checksum high byte
// ST_CKS_LO | next odd slot emits checksum low byte
module shared_data_tx
  import shared_data_pkg::*;
#(
  parameter int SEG_COUNT    = 32,
  parameter int COMMA_PERIOD = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_ready,
  input  logic                          event_valid,
  input  logic [7:0]                    event_code,
  output logic                          event_ready,
  input  logic [7:0]                    dbus,
  input  logic                          wr_en,
  input  logic [$clog2(SEG_COUNT)+3:0]  wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic                          send_valid,
  input  logic [$clog2(SEG_COUNT)-1:0]  send_seg,
  output logic                          send_ready,
  output logic [15:0]                   tx_data,
  output logic [1:0]                    tx_is_k
);

  localparam int SW = $clog2(SEG_COUNT);
  localparam int CW = $clog2(COMMA_PERIOD);

  seg_state_t      state;
  logic            phase;
  logic [CW-1:0]   comma_cnt;
  logic [3:0]      byte_idx;
  logic [SW-1:0]   seg_q;
  // Set for one cycle after a frame's last slot so frames never abut.
  logic            just_done;
  logic [7:0]      rd_data;
  logic            link_en;

`ifdef SHARED_DATA_TX_CHECKSUM_EN
  logic [CKS_W-1:0] acc;
  logic [CKS_W-1:0] cks;
  assign cks = {CKS_W{1'b1}} - acc;
`endif

  assign link_en     = tx_ready && !rst;
  assign event_ready = link_en && (comma_cnt != '0);
  assign send_ready  = link_en && (state == ST_IDLE) && !just_done;

  shared_data_seg_ram #(.SEG_COUNT(SEG_COUNT)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr ({seg_q, byte_idx}),
    .rd_data (rd_data)
  );

  // Event byte, phase, segment FSM and the registered output word.
  always_ff @(posedge clk) begin
    if (!link_en) begin
      state     <= ST_IDLE;
      phase     <= 1'b0;
      comma_cnt <= '0;
      byte_idx  <= '0;
      seg_q     <= '0;
      just_done <= 1'b0;
      tx_data   <= '0;
      tx_is_k   <= '0;
`ifdef SHARED_DATA_TX_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      comma_cnt <= (comma_cnt == CW'(COMMA_PERIOD - 1)) ? '0 : comma_cnt + 1'b1;
      phase     <= ~phase;
      just_done <= 1'b0;

      if (comma_cnt == '0) begin
        tx_data[7:0] <= K28_5;
        tx_is_k[0]   <= 1'b1;
      end else begin
        tx_data[7:0] <= event_valid ? event_code : 8'h00;
        tx_is_k[0]   <= 1'b0;
      end

      if (!phase) begin
        tx_data[15:8] <= dbus;
        tx_is_k[1]    <= 1'b0;
      end else begin
        tx_data[15:8] <= 8'h00;
        tx_is_k[1]    <= 1'b0;
        case (state)
          ST_IDLE: ;
          ST_START: begin
            tx_data[15:8] <= K28_2;
            tx_is_k[1]    <= 1'b1;
            state         <= ST_ADDR;
          end
          ST_ADDR: begin
            tx_data[15:8] <= 8'(seg_q);
            byte_idx      <= '0;
            state         <= ST_DATA;
          end
          ST_DATA: begin
            tx_data[15:8] <= rd_data;
`ifdef SHARED_DATA_TX_CHECKSUM_EN
            acc           <= acc + CKS_W'(rd_data);
`endif
            byte_idx      <= byte_idx + 1'b1;
            if (byte_idx == 4'hF) state <= ST_STOP;
          end
          ST_STOP: begin
            tx_data[15:8] <= K28_1;
            tx_is_k[1]    <= 1'b1;
`ifdef SHARED_DATA_TX_CHECKSUM_EN
            state         <= ST_CKS_HI;
`else
            state         <= ST_IDLE;
            just_done     <= 1'b1;
`endif
          end
`ifdef SHARED_DATA_TX_CHECKSUM_EN
          ST_CKS_HI: begin
            tx_data[15:8] <= cks[15:8];
            state         <= ST_CKS_LO;
          end
          ST_CKS_LO: begin
            tx_data[15:8] <= cks[7:0];
            state         <= ST_IDLE;
            just_done     <= 1'b1;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end

      if (send_valid && send_ready) begin
        seg_q    <= send_seg;
        byte_idx <= '0;
        state    <= ST_START;
`ifdef SHARED_DATA_TX_CHECKSUM_EN
        acc      <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_shared_data_tx.sv
// Bench for shared_data_tx: slot-token reference model, directed cases then random traffic.
module tb_shared_data_tx;

  localparam int SEG_COUNT    = 32;
  localparam int COMMA_PERIOD = 4;
  localparam int SW           = 5;
  localparam int AW           = 9;
`ifdef SHARED_DATA_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 21;
`else
  localparam int FRAME_LEN = 19;
`endif
  localparam int T_START = 100, T_ADDR = 101, T_STOP = 102, T_CHI = 103, T_CLO = 104;

  logic          clk = 1'b0;
  logic          rst, tx_ready, event_valid, event_ready, wr_en, send_valid, send_ready;
  logic [7:0]    event_code, dbus, wr_data;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] send_seg;
  logic [15:0]   tx_data;
  logic [1:0]    tx_is_k;

  always #5 clk = ~clk;

  shared_data_tx #(.SEG_COUNT(SEG_COUNT), .COMMA_PERIOD(COMMA_PERIOD)) dut (
    .clk(clk), .rst(rst), .tx_ready(tx_ready),
    .event_valid(event_valid), .event_code(event_code), .event_ready(event_ready),
    .dbus(dbus), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .send_valid(send_valid), .send_seg(send_seg), .send_ready(send_ready),
    .tx_data(tx_data), .tx_is_k(tx_is_k)
  );

  int n_cmp = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: link cycle count, queue of pending segment slots, buffer image.
  logic [7:0] mem [SEG_COUNT*16];
  int         cyc = 0;
  int         tok_q[$];
  int         cur_seg = 0;
  int         sum = 0;
  bit         gap = 0;
  bit         last_accept = 0;
  logic [8:0] p1_log[$];
  int         ev_acc = 0, ev_seen = 0;

  task automatic defaults();
    rst = 1'b0; tx_ready = 1'b1; event_valid = 1'b0; event_code = 8'h00;
    wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00; send_valid = 1'b0; send_seg = '0;
    dbus = 8'($urandom);
  endtask

  task automatic step();
    bit en, evr, sr, gap_next;
    logic [17:0] exp_w;
    logic [8:0]  hi;
    int t, cks;
    #1;
    en  = tx_ready && !rst;
    evr = en && (cyc % COMMA_PERIOD != 0);
    sr  = en && (tok_q.size() == 0) && !gap;
    check_val("event_ready", event_ready, evr);
    check_val("send_ready", send_ready, sr);
    last_accept = 0; gap_next = 0; exp_w = '0;
    if (en) begin
      if (cyc % COMMA_PERIOD == 0) begin
        exp_w[16] = 1'b1; exp_w[7:0] = 8'hBC;
      end else if (event_valid) begin
        exp_w[7:0] = event_code; ev_acc++;
      end
      if (cyc % 2 == 0) exp_w[15:8] = dbus;
      else if (tok_q.size() > 0) begin
        t = tok_q.pop_front();
        cks = (65535 - sum) & 16'hFFFF;
        case (t)
          T_START: hi = {1'b1, 8'h5C};
          T_ADDR:  hi = {1'b0, 8'(cur_seg)};
          T_STOP:  hi = {1'b1, 8'h3C};
          T_CHI:   hi = {1'b0, 8'(cks >> 8)};
          T_CLO:   hi = {1'b0, 8'(cks)};
          default: begin hi = {1'b0, mem[cur_seg*16 + t]}; sum += mem[cur_seg*16 + t]; end
        endcase
        exp_w[17] = hi[8]; exp_w[15:8] = hi[7:0];
        p1_log.push_back(hi);
        if (tok_q.size() == 0) gap_next = 1;
      end
      if (send_valid && sr) begin
        last_accept = 1; cur_seg = int'(send_seg); sum = 0;
        tok_q.push_back(T_START); tok_q.push_back(T_ADDR);
        for (int i = 0; i < 16; i++) tok_q.push_back(i);
        tok_q.push_back(T_STOP);
`ifdef SHARED_DATA_TX_CHECKSUM_EN
        tok_q.push_back(T_CHI); tok_q.push_back(T_CLO);
`endif
      end
      cyc++;
    end else begin
      cyc = 0; tok_q.delete();
    end
    if (wr_en) mem[wr_addr] = wr_data;
    @(posedge clk); #1;
    check_val("tx_word", {14'd0, tx_is_k, tx_data}, {14'd0, exp_w});
    if (!tx_is_k[0] && tx_data[7:0] == 8'h7E) ev_seen++;
    gap = en ? gap_next : 1'b0;
  endtask

  task automatic send(input int seg);
    p1_log.delete();
    for (int i = 0; i < 20; i++) begin
      defaults(); send_valid = 1'b1; send_seg = SW'(seg);
      step();
      if (last_accept) break;
    end
    defaults();
    check_val("send_accept", last_accept, 1);
  endtask

  task automatic run_until(input int n);
    for (int i = 0; i < 200 && p1_log.size() < n; i++) begin
      defaults(); step();
    end
    check_val("frame_wait", p1_log.size() >= n, 1);
  endtask

  initial begin
    logic [8:0] ef[$];
    logic [AW-1:0] a;
    defaults(); rst = 1'b1;
    step(); step();
    check_val("reset_word", {tx_is_k, tx_data}, 0);

    // Fill the whole buffer; segment 4 gets 0x01..0x10.
    for (int i = 0; i < SEG_COUNT*16; i++) begin
      defaults(); a = AW'(i);
      wr_en = 1'b1; wr_addr = a;
      wr_data = (a[AW-1:4] == 5'd4) ? 8'(a[3:0]) + 8'd1 : 8'($urandom);
      step();
    end

    // Idle link.
    for (int i = 0; i < 8; i++) begin defaults(); step(); end

    // Checksum frame on segment 4.
    send(4);
    run_until(FRAME_LEN);
    ef.push_back(9'h15C); ef.push_back(9'h004);
    for (int i = 1; i <= 16; i++) ef.push_back(9'(i));
    ef.push_back(9'h13C);
`ifdef SHARED_DATA_TX_CHECKSUM_EN
    ef.push_back(9'h0FF); ef.push_back(9'h077);
`endif
    for (int i = 0; i < FRAME_LEN; i++) check_val("frame_seg4", p1_log[i], ef[i]);

    // Event held continuously against comma slots.
    ev_acc = 0; ev_seen = 0;
    for (int i = 0; i < 20; i++) begin
      defaults(); event_valid = 1'b1; event_code = 8'h7E; step();
    end
    check_val("ev_accepted", ev_acc, 15);
    check_val("ev_seen", ev_seen, ev_acc);

    // Abort mid-frame around data byte 7.
    send(7);
    run_until(9);
    defaults(); step();
    defaults(); tx_ready = 1'b0; step();
    check_val("abort_word", {tx_is_k, tx_data}, 0);
    defaults(); tx_ready = 1'b0; step();
    defaults(); step();
    send(7);
    run_until(FRAME_LEN);
    check_val("abort_refr_len", p1_log.size(), FRAME_LEN);
    check_val("abort_refr_addr", p1_log[1], 9'h007);

    // Write collision: byte 15 of segment 4 rewritten while byte 3 is next.
    send(4);
    run_until(5);
    defaults(); wr_en = 1'b1; wr_addr = {5'd4, 4'd15}; wr_data = 8'hAA; step();
    run_until(FRAME_LEN);
    check_val("coll_b3", p1_log[5], 9'h004);
    check_val("coll_b15", p1_log[17], 9'h0AA);
`ifdef SHARED_DATA_TX_CHECKSUM_EN
    check_val("coll_cks_hi", p1_log[19], 9'h0FE);
    check_val("coll_cks_lo", p1_log[20], 9'h0DD);
`endif

    // Reset in the slot after STOP.
    send(4);
    run_until(19);
    defaults(); step();
    defaults(); rst = 1'b1; step();
    check_val("rst_word", {tx_is_k, tx_data}, 0);
    defaults(); step();
    check_val("rst_ready_prev", p1_log.size(), 19);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      defaults();
      tx_ready    = ($urandom_range(0, 99) >= 2);
      rst         = ($urandom_range(0, 199) == 0);
      event_valid = $urandom_range(0, 1);
      event_code  = 8'($urandom);
      wr_en       = ($urandom_range(0, 4) == 0);
      wr_addr     = AW'($urandom);
      wr_data     = 8'($urandom);
      send_valid  = ($urandom_range(0, 9) == 0);
      send_seg    = SW'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
